nibble_sel_sched: RTL and testbench

Scheduler that shares one selector4 nibble-selection datapath between two requesters, A and B. It arbitrates round-robin and sequences a burst of beats for the granted requester. On each beat it drives the per-lane nibble indices (selA/selB) and the per-lane source select (sel) consumed by selector4. It sits directly in front of selector4; downstream back-pressure arrives via out_ready.

---
 rtl/nibble_sel_pkg.sv | 19 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/nibble_sel_sched.sv | 113 +++++++++++
 tb/tb_nibble_sel_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_sel_pkg.sv
// Shared types and default sizes for the selector4 nibble path.
// Owner and FSM state enums plus default lane/index/length widths.
package nibble_sel_pkg;

  localparam int LANES_D = 4;
  localparam int IDX_W_D = 3;
  localparam int LEN_W_D = 4;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_e;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a last_owner register.
// Ports: clk, reset, req_a/req_b, done/done_owner in; one-hot gnt_a/gnt_b out.
module rr_arb2
  import nibble_sel_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_a,
  input  logic   req_b,
  input  logic   done,
  input  owner_e done_owner,
  output logic   gnt_a,
  output logic   gnt_b
);

  owner_e last_q;

  // On a tie the side that did not finish last wins.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (1'b1)
      (req_a && req_b): begin
        gnt_a = (last_q == OWN_B);
        gnt_b = (last_q == OWN_A);
      end
      (req_a && !req_b): gnt_a = 1'b1;
      (!req_a && req_b): gnt_b = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= OWN_B;
    end else if (done) begin
      last_q <= done_owner;
    end
  end

endmodule

// File: rtl/nibble_sel_sched.sv
// Burst scheduler sharing one selector4 datapath between A and B.
// Ports: req/len per side, out_ready in; gnt, sel, lane indices, beat flags out.
module nibble_sel_sched
  import nibble_sel_pkg::*;
#(
  parameter int LANES = LANES_D,
  parameter int IDX_W = IDX_W_D,
  parameter int LEN_W = LEN_W_D
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_a,
  input  logic [LEN_W-1:0]       len_a,
  input  logic                   req_b,
  input  logic [LEN_W-1:0]       len_b,
  input  logic                   out_ready,
  output logic                   gnt_a,
  output logic                   gnt_b,
  output logic [LANES-1:0]       sel,
  output logic [LANES*IDX_W-1:0] sel_a_idx,
  output logic [LANES*IDX_W-1:0] sel_b_idx,
  output logic                   beat_valid,
  output logic                   beat_last
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic pick_a, pick_b;
  logic done;
  logic run, last, accept;
  logic [LANES*IDX_W-1:0] idx;

  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_a      (req_a),
    .req_b      (req_b),
    .done       (done),
    .done_owner (owner_q),
    .gnt_a      (pick_a),
    .gnt_b      (pick_b)
  );

  assign run    = (state_q == RUN);
  assign last   = run && (beat_q == len_q);
  assign accept = run && out_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    len_d   = len_q;
    done    = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (pick_a || pick_b) begin
          state_d = RUN;
          owner_d = pick_b ? OWN_B : OWN_A;
          len_d   = pick_b ? len_b : len_a;
          beat_d  = '0;
        end
      end
      (state_q == RUN): begin
        if (accept) begin
          if (last) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane indices wrap naturally in IDX_W bits.
  always_comb begin
    idx = '0;
    for (int i = 0; i < LANES; i++) begin
      idx[i*IDX_W +: IDX_W] =
        IDX_W'(int'(beat_q) * LANES + i);
    end
  end

  // Outputs decode from registers only, so they stay
  // glitch-free during stalls and clear with async reset.
  assign gnt_a      = run && (owner_q == OWN_A);
  assign gnt_b      = run && (owner_q == OWN_B);
  assign beat_valid = run;
  assign beat_last  = last;
  assign sel        = {LANES{gnt_b}};
  assign sel_a_idx  = gnt_a ? idx : '0;
  assign sel_b_idx  = gnt_b ? idx : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_A;
      beat_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_nibble_sel_sched.sv
// Scoreboard bench for nibble_sel_sched.
// Expected beats are queued at stimulus time and popped on accept.
module tb_nibble_sel_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [3:0]  len_a, len_b;
  logic        out_ready;
  logic        gnt_a, gnt_b;
  logic [3:0]  sel;
  logic [11:0] sel_a_idx, sel_b_idx;
  logic        beat_valid, beat_last;

  typedef struct packed {
    logic        own_b;
    logic [3:0]  sel;
    logic [11:0] ia;
    logic [11:0] ib;
    logic        last;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_err = 0;

  nibble_sel_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req_a      (req_a),
    .len_a      (len_a),
    .req_b      (req_b),
    .len_b      (len_b),
    .out_ready  (out_ready),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .sel        (sel),
    .sel_a_idx  (sel_a_idx),
    .sel_b_idx  (sel_b_idx),
    .beat_valid (beat_valid),
    .beat_last  (beat_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pat(input int b);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*3 +: 3] = 3'((b * 4 + i) % 8);
    return r;
  endfunction

  task automatic push_burst(input logic ob, input int len);
    exp_t e;
    for (int b = 0; b <= len; b++) begin
      e.own_b = ob;
      e.sel   = ob ? 4'hF : 4'h0;
      e.ia    = ob ? 12'h0 : pat(b);
      e.ib    = ob ? pat(b) : 12'h0;
      e.last  = (b == len);
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && q.size() > 0; i++) tick();
    chk("drain", q.size(), 0);
  endtask

  function automatic logic [31:0] outs();
    return {gnt_a, gnt_b, sel, sel_a_idx, sel_b_idx,
            beat_valid, beat_last};
  endfunction

  always @(negedge clk) begin
    chk("excl", 32'(gnt_a & gnt_b), 0);
    chk("vld_eq", 32'(beat_valid), 32'(gnt_a | gnt_b));
    if (beat_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexp_beat", 1, 0);
      end else begin
        m_e = q.pop_front();
        chk("own_b", 32'(gnt_b), 32'(m_e.own_b));
        chk("gnt_a", 32'(gnt_a), 32'(!m_e.own_b));
        chk("sel", 32'(sel), 32'(m_e.sel));
        chk("ia", 32'(sel_a_idx), 32'(m_e.ia));
        chk("ib", 32'(sel_b_idx), 32'(m_e.ib));
        chk("last", 32'(beat_last), 32'(m_e.last));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    len_a = '0;
    len_b = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_outs", outs(), 0);
    reset = 1'b0;
    tick();
    chk("idle_outs", outs(), 0);

    // A, two beats
    req_a = 1'b1;
    len_a = 4'd1;
    push_burst(1'b0, 1);
    tick();
    req_a = 1'b0;
    chk("t1_gnt_a", gnt_a, 1);
    chk("t1_sel", sel, 0);
    chk("t1_ia0", sel_a_idx, 12'h688);
    chk("t1_last0", beat_last, 0);
    tick();
    chk("t1_ia1", sel_a_idx, 12'hFAC);
    chk("t1_last1", beat_last, 1);
    tick();
    chk("t1_after", outs(), 0);
    drain(4);

    // both held after reset: A, idle, B, idle, A
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    len_a = '0;
    len_b = '0;
    push_burst(1'b0, 0);
    push_burst(1'b1, 0);
    push_burst(1'b0, 0);
    tick();
    chk("t2_first_a", gnt_a, 1);
    tick();
    chk("t2_bubble1", beat_valid, 0);
    tick();
    chk("t2_second_b", gnt_b, 1);
    tick();
    chk("t2_bubble2", beat_valid, 0);
    tick();
    chk("t2_third_a", gnt_a, 1);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    chk("t2_end", outs(), 0);
    drain(4);

    // B len 2, stall 3 cycles on beat 1
    req_b = 1'b1;
    len_b = 4'd2;
    push_burst(1'b1, 2);
    tick();
    req_b = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_sel", sel, 4'hF);
      chk("t3_ib", sel_b_idx, 12'hFAC);
      chk("t3_ia", sel_a_idx, 0);
      chk("t3_vld", beat_valid, 1);
      chk("t3_last", beat_last, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3_ib2", sel_b_idx, 12'h688);
    chk("t3_last2", beat_last, 1);
    drain(4);
    tick();

    // single beat
    req_a = 1'b1;
    len_a = '0;
    push_burst(1'b0, 0);
    tick();
    req_a = 1'b0;
    chk("t4_vld", beat_valid, 1);
    chk("t4_last", beat_last, 1);
    chk("t4_ia", sel_a_idx, 12'h688);
    tick();
    chk("t4_idle", outs(), 0);
    drain(2);

    // async reset on beat 1 of len 3
    req_a = 1'b1;
    len_a = 4'd3;
    push_burst(1'b0, 3);
    tick();
    req_a = 1'b0;
    tick();
    chk("t5_beat1", sel_a_idx, 12'hFAC);
    out_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("t5_async", outs(), 0);
    q.delete();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    req_a = 1'b1;
    req_b = 1'b1;
    len_a = '0;
    len_b = '0;
    push_burst(1'b0, 0);
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    chk("t5_a_first", {gnt_a, gnt_b}, 2'b10);
    tick();
    drain(2);

    // req and len change after grant are ignored
    req_a = 1'b1;
    len_a = 4'd3;
    push_burst(1'b0, 3);
    tick();
    req_a = 1'b0;
    len_a = '0;
    drain(8);
    tick();
    chk("t6_idle", outs(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
